// File: rtl/load_buffer_pkg.sv
// Shared load-buffer constants: widths, load opcode encodings, FSM states
// and the opcode-to-access-size helper.
package load_buffer_pkg;

  localparam int ROB_WIDTH     = 4;
  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int INST_W        = 6;

  // Load instruction-type encodings
  localparam logic [INST_W-1:0] OPC_LB  = 6'd11;
  localparam logic [INST_W-1:0] OPC_LH  = 6'd12;
  localparam logic [INST_W-1:0] OPC_LW  = 6'd13;
  localparam logic [INST_W-1:0] OPC_LBU = 6'd14;
  localparam logic [INST_W-1:0] OPC_LHU = 6'd15;

  // ROB tag 0 means "nothing on the CDB"
  localparam logic [ROB_WIDTH-1:0] ROB_NONE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } lb_state_e;

  // Number of bytes the memory controller must read for a load opcode
  function automatic logic [2:0] mem_size_of(input logic [INST_W-1:0] opc);
    logic [2:0] size;
    case (opc)
      OPC_LB, OPC_LBU: size = 3'd1;
      OPC_LH, OPC_LHU: size = 3'd2;
      OPC_LW:          size = 3'd4;
      default:         size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_buffer_fifo.sv
// In-order circular buffer of resolved loads: push at tail, pop at head,
// synchronous clear for pipeline flushes, everything frozen when en_in is low.
module load_buffer_fifo
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 42,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             clr_in,
  input  logic             push_in,
  input  logic [W-1:0]     push_data_in,
  input  logic             pop_in,
  output logic [W-1:0]     head_data_out,
  output logic [CNT_W-1:0] count_out
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s;

  // A pop on an empty buffer is ignored so the count can never underflow
  always_comb begin
    pop_s = 1'b0;
    if (pop_in && (count_r != {CNT_W{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Pointer, count and storage update; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (en_in) begin
      if (clr_in) begin
        head_r  <= {PTR_W{1'b0}};
        tail_r  <= {PTR_W{1'b0}};
        count_r <= {CNT_W{1'b0}};
      end else begin
        if (push_in) begin
          mem_r[tail_r] <= push_data_in;
          tail_r        <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        case ({push_in, pop_s})
          2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
          default: count_r <= count_r;
        endcase
      end
    end
  end

  assign head_data_out = mem_r[head_r];
  assign count_out     = count_r;

endmodule

// File: rtl/load_buffer.sv
// Load buffer: queues address-resolved loads, issues them one at a time to
// memory, extends the returned data and broadcasts it on the load CDB lane.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LB_DEPTH = 4,
  parameter int ROB_W    = ROB_WIDTH,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int ADDR_W   = ADDRESS_WIDTH,
  parameter int OPC_W    = INST_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  output logic              lbuffer_rs_rdy_out,
  input  logic              addrunit_lbuffer_en_in,
  input  logic [ADDR_W-1:0] addrunit_lbuffer_addr_in,
  input  logic [ROB_W-1:0]  addrunit_lbuffer_dest_in,
  input  logic [OPC_W-1:0]  addrunit_lbuffer_opcode_in,
  output logic              lbuffer_mem_en_out,
  output logic [ADDR_W-1:0] lbuffer_mem_addr_out,
  output logic [2:0]        lbuffer_mem_size_out,
  input  logic              mem_lbuffer_done_in,
  input  logic [DATA_W-1:0] mem_lbuffer_data_in,
  input  logic              rob_lbuffer_rst_in,
  output logic [ROB_W-1:0]  cdb_lbuffer_b_out,
  output logic [DATA_W-1:0] cdb_lbuffer_result_out
);

  localparam int ENTRY_W = ADDR_W + ROB_W + OPC_W;
  localparam int CNT_W   = $clog2(LB_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LB_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(2);

  lb_state_e           state_r;
  logic                mem_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [2:0]          mem_size_r;
  logic [ROB_W-1:0]    cdb_b_r;
  logic [DATA_W-1:0]   cdb_result_r;

  logic                push_s;
  logic                pop_s;
  logic [ENTRY_W-1:0]  head_s;
  logic [CNT_W-1:0]    count_s;
  logic [CNT_W-1:0]    free_s;
  logic [ADDR_W-1:0]   head_addr_s;
  logic [ROB_W-1:0]    head_dest_s;
  logic [OPC_W-1:0]    head_opc_s;

  // Sign/zero extension of right-aligned memory data according to the load type
  function automatic logic [DATA_W-1:0] ext_load(input logic [DATA_W-1:0] d,
                                                 input logic [OPC_W-1:0]  opc);
    logic [DATA_W-1:0] r;
    case (opc)
      OPC_LB:  r = {{(DATA_W-8){d[7]}}, d[7:0]};
      OPC_LBU: r = {{(DATA_W-8){1'b0}}, d[7:0]};
      OPC_LH:  r = {{(DATA_W-16){d[15]}}, d[15:0]};
      OPC_LHU: r = {{(DATA_W-16){1'b0}}, d[15:0]};
      OPC_LW:  r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign head_addr_s = head_s[ENTRY_W-1 -: ADDR_W];
  assign head_dest_s = head_s[OPC_W +: ROB_W];
  assign head_opc_s  = head_s[OPC_W-1:0];

  // Flush drops any push in the same cycle; the head leaves only on a real completion
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (rob_lbuffer_rst_in) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = addrunit_lbuffer_en_in;
      pop_s  = (state_r == ST_WAIT) && mem_lbuffer_done_in;
    end
  end

  load_buffer_fifo #(
    .DEPTH (LB_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .en_in         (rdy_in),
    .clr_in        (rob_lbuffer_rst_in),
    .push_in       (push_s),
    .push_data_in  ({addrunit_lbuffer_addr_in, addrunit_lbuffer_dest_in, addrunit_lbuffer_opcode_in}),
    .pop_in        (pop_s),
    .head_data_out (head_s),
    .count_out     (count_s)
  );

  // Two free entries are required because one load may already be in flight from the RS
  assign free_s             = DEPTH_C - count_s;
  assign lbuffer_rs_rdy_out = (free_s >= MARGIN_C);

  // Issue/complete FSM with registered memory request and CDB outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= ST_IDLE;
      mem_en_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_size_r   <= 3'd0;
      cdb_b_r      <= ROB_NONE;
      cdb_result_r <= {DATA_W{1'b0}};
    end else if (rdy_in) begin
      cdb_b_r <= ROB_NONE;
      case (state_r)
        ST_IDLE: begin
          if (!rob_lbuffer_rst_in && (count_s != {CNT_W{1'b0}})) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= head_addr_s;
            mem_size_r <= mem_size_of(head_opc_s);
            state_r    <= ST_WAIT;
          end else begin
            mem_en_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_lbuffer_done_in) begin
            if (!rob_lbuffer_rst_in) begin
              cdb_b_r      <= head_dest_s;
              cdb_result_r <= ext_load(mem_lbuffer_data_in, head_opc_s);
            end
            mem_en_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (rob_lbuffer_rst_in) begin
            // The outstanding read must still finish before anything new issues
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (mem_lbuffer_done_in) begin
            mem_en_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          mem_en_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign lbuffer_mem_en_out     = mem_en_r;
  assign lbuffer_mem_addr_out   = mem_addr_r;
  assign lbuffer_mem_size_out   = mem_size_r;
  assign cdb_lbuffer_b_out      = cdb_b_r;
  assign cdb_lbuffer_result_out = cdb_result_r;

endmodule

// File: tb/tb_load_buffer.sv
// Directed testbench for load_buffer with hand-computed expected values.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        rs_rdy;
  logic        en;
  logic [31:0] addr;
  logic [3:0]  dest;
  logic [5:0]  opc;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic        done;
  logic [31:0] mdata;
  logic        flush;
  logic [3:0]  cdb_b;
  logic [31:0] cdb_res;

  int n_checks = 0;
  int n_pass   = 0;

  load_buffer dut (
    .clk_in                     (clk_in),
    .rst_n_in                   (rst_n_in),
    .rdy_in                     (rdy_in),
    .lbuffer_rs_rdy_out         (rs_rdy),
    .addrunit_lbuffer_en_in     (en),
    .addrunit_lbuffer_addr_in   (addr),
    .addrunit_lbuffer_dest_in   (dest),
    .addrunit_lbuffer_opcode_in (opc),
    .lbuffer_mem_en_out         (mem_en),
    .lbuffer_mem_addr_out       (mem_addr),
    .lbuffer_mem_size_out       (mem_size),
    .mem_lbuffer_done_in        (done),
    .mem_lbuffer_data_in        (mdata),
    .rob_lbuffer_rst_in         (flush),
    .cdb_lbuffer_b_out          (cdb_b),
    .cdb_lbuffer_result_out     (cdb_res)
  );

  always #5 clk_in = ~clk_in;

  // Protocol guard: the address unit must never push into a full buffer
  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in && en && !flush) begin
      assert (dut.count_s != 3'd4) else $error("FAIL push_while_full");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] d, input logic [5:0] o);
    en = 1'b1; addr = a; dest = d; opc = o;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_mem_en(input string tag);
    int n = 0;
    while (!mem_en && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, mem_en}, 32'd1);
  endtask

  task automatic complete(input string tag, input logic [31:0] d,
                          input logic [3:0] exp_b, input logic [31:0] exp_res);
    done = 1'b1; mdata = d;
    tick();
    done = 1'b0;
    check_eq({tag, "_b"}, {28'd0, cdb_b}, {28'd0, exp_b});
    check_eq({tag, "_res"}, cdb_res, exp_res);
    check_eq({tag, "_en_drop"}, {31'd0, mem_en}, 32'd0);
    tick();
    check_eq({tag, "_b_clr"}, {28'd0, cdb_b}, 32'd0);
  endtask

  logic [5:0]  t2_opc [4] = '{OPC_LBU, OPC_LH, OPC_LHU, OPC_LW};
  logic [31:0] t2_dat [4] = '{32'h0000_8081, 32'h0000_8081, 32'h0000_8081, 32'hDEAD_BEEF};
  logic [31:0] t2_exp [4] = '{32'h0000_0081, 32'hFFFF_8081, 32'h0000_8081, 32'hDEAD_BEEF};
  logic [2:0]  t2_siz [4] = '{3'd1, 3'd2, 3'd2, 3'd4};

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; en = 1'b0; addr = 32'd0; dest = 4'd0;
    opc = 6'd0; done = 1'b0; mdata = 32'd0; flush = 1'b0;
    #1;
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_cdb_b", {28'd0, cdb_b}, 32'd0);
    check_eq("rst_rdy", {31'd0, rs_rdy}, 32'd1);
    #11 rst_n_in = 1'b1;
    tick();

    // Single LB with sign extension
    push(32'h0000_1000, 4'd3, OPC_LB);
    check_eq("t1_no_early_en", {31'd0, mem_en}, 32'd0);
    tick();
    check_eq("t1_en", {31'd0, mem_en}, 32'd1);
    check_eq("t1_addr", mem_addr, 32'h0000_1000);
    check_eq("t1_size", {29'd0, mem_size}, 32'd1);
    tick(); tick();
    complete("t1", 32'h0000_00F0, 4'd3, 32'hFFFF_FFF0);

    // Extension variants
    for (int i = 0; i < 4; i++) begin
      push(32'h0000_2000 + 32'(i * 4), 4'(4 + i), t2_opc[i]);
      wait_mem_en("t2_en");
      check_eq("t2_size", {29'd0, mem_size}, {29'd0, t2_siz[i]});
      complete("t2", t2_dat[i], 4'(4 + i), t2_exp[i]);
    end

    // Three back-to-back pushes, ready flag and in-order completion
    push(32'h0000_3000, 4'd1, OPC_LW);
    check_eq("t3_rdy_c1", {31'd0, rs_rdy}, 32'd1);
    push(32'h0000_3004, 4'd2, OPC_LW);
    check_eq("t3_rdy_c2", {31'd0, rs_rdy}, 32'd1);
    push(32'h0000_3008, 4'd3, OPC_LW);
    check_eq("t3_rdy_c3", {31'd0, rs_rdy}, 32'd0);
    check_eq("t3_addr1", mem_addr, 32'h0000_3000);
    complete("t3_1", 32'h1111_1111, 4'd1, 32'h1111_1111);
    check_eq("t3_rdy_back", {31'd0, rs_rdy}, 32'd1);
    wait_mem_en("t3_en2");
    check_eq("t3_addr2", mem_addr, 32'h0000_3004);
    complete("t3_2", 32'h2222_2222, 4'd2, 32'h2222_2222);
    wait_mem_en("t3_en3");
    check_eq("t3_addr3", mem_addr, 32'h0000_3008);
    complete("t3_3", 32'h3333_3333, 4'd3, 32'h3333_3333);

    // Flush in WAIT with two queued, push during DRAIN
    push(32'h0000_6000, 4'd5, OPC_LW);
    push(32'h0000_6004, 4'd6, OPC_LW);
    wait_mem_en("t4_en");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("t4_drain_en", {31'd0, mem_en}, 32'd1);
    check_eq("t4_flush_b", {28'd0, cdb_b}, 32'd0);
    check_eq("t4_flush_rdy", {31'd0, rs_rdy}, 32'd1);
    push(32'h0000_7000, 4'd7, OPC_LW);
    check_eq("t4_drain_hold", mem_addr, 32'h0000_6000);
    tick();
    check_eq("t4_drain_en2", {31'd0, mem_en}, 32'd1);
    done = 1'b1; mdata = 32'h0000_AAAA;
    tick();
    done = 1'b0;
    check_eq("t4_no_bcast", {28'd0, cdb_b}, 32'd0);
    check_eq("t4_en_drop", {31'd0, mem_en}, 32'd0);
    tick();
    check_eq("t4_post_en", {31'd0, mem_en}, 32'd1);
    check_eq("t4_post_addr", mem_addr, 32'h0000_7000);
    complete("t4", 32'h0000_0077, 4'd7, 32'h0000_0077);
    check_eq("t4_empty", {31'd0, mem_en}, 32'd0);

    // rdy_in low freezes everything, including a push attempt
    push(32'h0000_3000, 4'd9, OPC_LW);
    wait_mem_en("t5_en");
    rdy_in = 1'b0;
    en = 1'b1; addr = 32'h0000_4444; dest = 4'd10; opc = OPC_LW;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_frz_en", {31'd0, mem_en}, 32'd1);
      check_eq("t5_frz_addr", mem_addr, 32'h0000_3000);
      check_eq("t5_frz_b", {28'd0, cdb_b}, 32'd0);
    end
    en = 1'b0;
    rdy_in = 1'b1;
    complete("t5", 32'h1234_5678, 4'd9, 32'h1234_5678);
    tick();
    check_eq("t5_no_leak", {31'd0, mem_en}, 32'd0);

    // Asynchronous reset mid-WAIT
    push(32'h0000_5000, 4'd11, OPC_LH);
    wait_mem_en("t6_en");
    #3 rst_n_in = 1'b0;
    #1;
    check_eq("t6_en", {31'd0, mem_en}, 32'd0);
    check_eq("t6_addr", mem_addr, 32'd0);
    check_eq("t6_size", {29'd0, mem_size}, 32'd0);
    check_eq("t6_b", {28'd0, cdb_b}, 32'd0);
    check_eq("t6_res", cdb_res, 32'd0);
    check_eq("t6_rdy", {31'd0, rs_rdy}, 32'd1);
    #2 rst_n_in = 1'b1;
    tick(); tick();
    check_eq("t6_idle", {31'd0, mem_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
Name: load_buffer

Overview:
- Consumer end of the RS load path: accepts address-resolved loads from the address unit, which sends them only when the RS has seen this block's ready flag.
- Holds loads in an in-order FIFO and issues them one at a time to the memory controller.
- Sign/zero-extends each returned value and broadcasts it on the load-buffer CDB lane (b, result) that the RS and ROB snoop.
- Drives the ready flag the RS samples before releasing a load.

Parameters:
LB_DEPTH, 4, FIFO entries (power of two, >= 2)
ROB_W, 4, ROB tag width; tag 0 means "no broadcast"
DATA_W, 32, data width
ADDR_W, 32, address width
OPC_W, 6, instruction-type width (encodings LB/LH/LW/LBU/LHU from the shared constants)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; when low, all state holds
lbuffer_rs_rdy_out  output  1  high when at least 2 free entries
addrunit_lbuffer_en_in  input  1  load push valid
addrunit_lbuffer_addr_in  input  ADDR_W  effective address
addrunit_lbuffer_dest_in  input  ROB_W  ROB tag
addrunit_lbuffer_opcode_in  input  OPC_W  LB..LHU
lbuffer_mem_en_out  output  1  memory read request, held until done
lbuffer_mem_addr_out  output  ADDR_W  request address
lbuffer_mem_size_out  output  3  bytes to read: 1, 2 or 4
mem_lbuffer_done_in  input  1  one-cycle response pulse
mem_lbuffer_data_in  input  DATA_W  right-aligned read data
rob_lbuffer_rst_in  input  1  misprediction flush
cdb_lbuffer_b_out  output  ROB_W  broadcast tag; 0 when idle
cdb_lbuffer_result_out  output  DATA_W  broadcast value

Behaviour:
- Reset (rst_n_in low, asynchronous): FIFO empty, FSM IDLE, mem_en 0, mem_addr 0, mem_size 0, cdb_b 0, cdb_result 0. lbuffer_rs_rdy_out is 1 because it decodes from the empty count.
- rdy_in low: no register changes. The memory controller shares rdy_in, so done never arrives while rdy_in is low.
- Ready flag: lbuffer_rs_rdy_out = (LB_DEPTH - count) >= 2. This is combinational from count. The 2-entry margin covers the RS-to-address-unit pipeline, which has one load in flight.
- Push: when en_in is high, write {addr, dest, opcode} at tail and increment tail (mod LB_DEPTH).
  - Push while full is a protocol violation; the bench asserts it never happens.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- FSM states IDLE, WAIT, DRAIN, all registered:
  - IDLE: if the FIFO is non-empty and there is no flush, drive mem_en=1, mem_addr=head.addr and mem_size from the opcode (LB/LBU=1, LH/LHU=2, LW=4). Go to WAIT.
  - WAIT: mem outputs hold. On done, register cdb_b=head.dest and cdb_result=ext(data, head.opcode), pop head, drop mem_en and go to IDLE. IDLE may issue the next head on the following cycle.
  - DRAIN: mem_en stays high until done. On done, discard the data (no broadcast), drop mem_en and go to IDLE.
- Extension:
  - LB sign-extends data[7:0]; LBU zero-extends data[7:0].
  - LH sign-extends data[15:0]; LHU zero-extends data[15:0].
  - LW passes data through.
- CDB: cdb_b is nonzero for exactly one cycle per completed load and is otherwise 0. cdb_result holds its last value.
- Latency:
  - A push to an empty FIFO at edge t raises mem_en after edge t+1.
  - Done sampled at edge d puts the tag on the CDB after edge d; it is visible in cycle d+1.
- Flush (rob_lbuffer_rst_in high with rdy_in high):
  - Always empties the FIFO, forces cdb_b to 0 and drops any push in that cycle.
  - In IDLE: stay in IDLE with mem_en 0.
  - In WAIT without done: go to DRAIN, because the memory controller must finish the transaction.
  - In WAIT with done: discard the data and go to IDLE.
  - In DRAIN: stay in DRAIN.
  - New pushes are accepted while in DRAIN, but none issue until DRAIN exits.
- Pointers are log2(LB_DEPTH) bits and wrap naturally. count is log2(LB_DEPTH)+1 bits.

Decomposition:
- Shared package (constant.vh): widths (IDWidth, ROBWidth, AddressWidth, InstTypeWidth), the LB..LHU opcode encodings and the ROB tag-0 "none" convention.
- Sub-module lb_fifo: circular buffer with push, pop, head data and count. The top level holds the FSM, the extension logic and the CDB registers.

Test Plan:
- Single LB at 0x1000, dest 3; memory returns 0x000000F0 two cycles later. Required: mem_size=1, then cdb_b=3 and result 0xFFFFFFF0 for exactly one cycle, then cdb_b returns to 0.
- LBU, LH and LHU with data 0x0000_8081, plus LW with data 0xDEADBEEF. Required results: 0x00000081, 0xFFFF8081, 0x00008081, 0xDEADBEEF.
- Push 3 loads back-to-back (dests 1, 2, 3). Required: rdy_out falls to 0 once count reaches 3, broadcasts arrive in order 1, 2, 3, and rdy_out returns high once count drops to 2.
- Flush while in WAIT with 2 queued, then done arrives 3 cycles later. Required: no broadcast, FIFO empty, and mem_en stays high until done and then falls. A load pushed during DRAIN issues after DRAIN exits.
- Hold rdy_in low for 5 cycles in the middle of WAIT. Required: all outputs frozen; completion resumes normally afterwards.
- Assert rst_n_in asynchronously mid-WAIT. Required: all outputs zero within the same cycle, and rdy_out=1.
